// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned ADDR_WIDTH     = 5;
  localparam int unsigned MAX_READ_PORTS = 4;

  typedef logic [DATA_WIDTH-1:0] regfile_data_t;
  typedef logic [ADDR_WIDTH-1:0] regfile_addr_t;

  localparam regfile_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: tracks registers whose producer has issued but not
// yet written back, and keeps a registered count of them.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDR_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr0_en,
  input  logic [ADDRESS_WIDTH-1:0] wr0_addr,
  input  logic                     wr1_en,
  input  logic [ADDRESS_WIDTH-1:0] wr1_addr,
  input  logic                     issue,
  input  logic [ADDRESS_WIDTH-1:0] issue_addr,
  output logic [2**ADDRESS_WIDTH-1:0] pending,
  output logic [ADDRESS_WIDTH:0]   busy_count
);

  localparam int unsigned DEPTH = 2**ADDRESS_WIDTH;
  localparam int unsigned CW    = ADDRESS_WIDTH + 1;

  logic [DEPTH-1:0] pending_next;
  logic [CW-1:0]    count_next;

  // Writebacks clear first, then issue sets, so a new producer outranks the old writeback.
  always_comb begin
    pending_next = pending;
    count_next   = '0;
    if (wr0_en) pending_next[wr0_addr] = 1'b0;
    if (wr1_en) pending_next[wr1_addr] = 1'b0;
    if (issue && (issue_addr != ADDRESS_WIDTH'(REG_ZERO))) pending_next[issue_addr] = 1'b1;
    pending_next[0] = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_next = count_next + CW'(pending_next[i]);
    end
  end

  // Pending bits and their popcount update on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      busy_count <= '0;
    end else begin
      pending    <= pending_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-tracking scoreboard.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH         = DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = ADDR_WIDTH,
  parameter int unsigned READ_PORTS    = 2
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                we0,
  input  logic [ADDRESS_WIDTH-1:0]            wa0,
  input  logic [WIDTH-1:0]                    wd0,
  input  logic                                we1,
  input  logic [ADDRESS_WIDTH-1:0]            wa1,
  input  logic [WIDTH-1:0]                    wd1,
  input  logic                                issue,
  input  logic [ADDRESS_WIDTH-1:0]            issue_addr,
  input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] ra,
  output logic [READ_PORTS*WIDTH-1:0]         rd,
  output logic [READ_PORTS-1:0]               rbusy,
  output logic [ADDRESS_WIDTH:0]              busy_count
);

  localparam int unsigned DEPTH = 2**ADDRESS_WIDTH;

  if (READ_PORTS < 1 || READ_PORTS > MAX_READ_PORTS) begin : g_bad_ports
    $error("regfile_mp_sb: READ_PORTS out of range");
  end

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             w0_en;
  logic             w1_en;

  // Register 0 is never written; port 1 wins an address collision.
  assign w1_en = we1 && (wa1 != ADDRESS_WIDTH'(REG_ZERO));
  assign w0_en = we0 && (wa0 != ADDRESS_WIDTH'(REG_ZERO)) && !(w1_en && (wa1 == wa0));

  // Storage array, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (w0_en) regs[wa0] <= wd0;
      if (w1_en) regs[wa1] <= wd1;
    end
  end

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_scoreboard (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr0_en     (w0_en),
    .wr0_addr   (wa0),
    .wr1_en     (w1_en),
    .wr1_addr   (wa1),
    .issue      (issue),
    .issue_addr (issue_addr),
    .pending    (pending),
    .busy_count (busy_count)
  );

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [WIDTH-1:0]         data;
    logic                     busy;

    assign addr = ra[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    // Combinational read mux; register 0 always reads as zero and idle.
    always_comb begin
      data = regs[addr];
      busy = pending[addr];
`ifdef REGFILE_BYPASS_EN
      if (reset_n && w1_en && (wa1 == addr)) begin
        data = wd1;
        busy = issue && (issue_addr == addr);
      end else if (reset_n && w0_en && (wa0 == addr)) begin
        data = wd0;
        busy = issue && (issue_addr == addr);
      end
`endif
      if (addr == ADDRESS_WIDTH'(REG_ZERO)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd[k*WIDTH +: WIDTH] = data;
    assign rbusy[k]             = busy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (default build, no bypass).
module tb_regfile_mp_sb;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        we0, we1, issue;
  logic [4:0]  wa0, wa1, issue_addr;
  logic [7:0]  wd0, wd1;
  logic [9:0]  ra;
  logic [15:0] rd;
  logic [1:0]  rbusy;
  logic [5:0]  busy_count;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp_sb dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .we0        (we0),
    .wa0        (wa0),
    .wd0        (wd0),
    .we1        (we1),
    .wa1        (wa1),
    .wd1        (wd1),
    .issue      (issue),
    .issue_addr (issue_addr),
    .ra         (ra),
    .rd         (rd),
    .rbusy      (rbusy),
    .busy_count (busy_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read two addresses and compare data and busy on both ports.
  task automatic rd_check(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic b0, input logic b1);
    ra = {a1, a0};
    #1;
    check({tag, ".rd0"}, 32'(rd[7:0]), 32'(d0));
    check({tag, ".rd1"}, 32'(rd[15:8]), 32'(d1));
    check({tag, ".busy0"}, 32'(rbusy[0]), 32'(b0));
    check({tag, ".busy1"}, 32'(rbusy[1]), 32'(b1));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    we0 = 1'b0; we1 = 1'b0; issue = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    we0 = 0; we1 = 0; issue = 0;
    wa0 = 0; wa1 = 0; issue_addr = 0; wd0 = 0; wd1 = 0; ra = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    step();

    // Reset state everywhere
    check("reset.count", 32'(busy_count), 32'd0);
    for (int a = 0; a < 32; a++) begin
      rd_check("reset.all", 5'(a), 5'(31 - a), 8'h00, 8'h00, 1'b0, 1'b0);
    end

    // Basic write, r0 write ignored
    we0 = 1; wa0 = 5'd3; wd0 = 8'hA5;
    rd_check("wr.r3_pre", 5'd3, 5'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    rd_check("wr.r3", 5'd3, 5'd3, 8'hA5, 8'hA5, 1'b0, 1'b0);
    we0 = 1; wa0 = 5'd0; wd0 = 8'hFF;
    step();
    rd_check("wr.r0", 5'd0, 5'd3, 8'h00, 8'hA5, 1'b0, 1'b0);

    // Same-address collision: port 1 wins
    we0 = 1; wa0 = 5'd7; wd0 = 8'h11;
    we1 = 1; wa1 = 5'd7; wd1 = 8'h22;
    rd_check("coll.pre", 5'd7, 5'd7, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    rd_check("coll.r7", 5'd7, 5'd3, 8'h22, 8'hA5, 1'b0, 1'b0);

    // Different addresses on both ports commit together
    we0 = 1; wa0 = 5'd10; wd0 = 8'h10;
    we1 = 1; wa1 = 5'd11; wd1 = 8'h20;
    step();
    rd_check("dual", 5'd10, 5'd11, 8'h10, 8'h20, 1'b0, 1'b0);

    // Issue sequence r5, r9, r5 again, r0 ignored
    issue = 1; issue_addr = 5'd5;
    step();
    check("iss.c1", 32'(busy_count), 32'd1);
    rd_check("iss.r5", 5'd5, 5'd9, 8'h00, 8'h00, 1'b1, 1'b0);
    issue = 1; issue_addr = 5'd9;
    step();
    check("iss.c2", 32'(busy_count), 32'd2);
    issue = 1; issue_addr = 5'd5;
    step();
    check("iss.c2b", 32'(busy_count), 32'd2);
    issue = 1; issue_addr = 5'd0;
    step();
    check("iss.r0", 32'(busy_count), 32'd2);
    rd_check("iss.r0rd", 5'd0, 5'd9, 8'h00, 8'h00, 1'b0, 1'b1);

    // Writeback clears r5
    we0 = 1; wa0 = 5'd5; wd0 = 8'h55;
    rd_check("wb.pre", 5'd5, 5'd9, 8'h00, 8'h00, 1'b1, 1'b1);
    step();
    check("wb.count", 32'(busy_count), 32'd1);
    rd_check("wb.r5", 5'd5, 5'd9, 8'h55, 8'h00, 1'b0, 1'b1);

    // Issue and write to same register: stays busy
    issue = 1; issue_addr = 5'd4;
    we1 = 1; wa1 = 5'd4; wd1 = 8'h3C;
    step();
    check("iw.count", 32'(busy_count), 32'd2);
    rd_check("iw.r4", 5'd4, 5'd9, 8'h3C, 8'h00, 1'b1, 1'b1);

    // Two writebacks in one cycle: -2
    we0 = 1; wa0 = 5'd9; wd0 = 8'h99;
    we1 = 1; wa1 = 5'd4; wd1 = 8'h44;
    step();
    check("wb2.count", 32'(busy_count), 32'd0);
    rd_check("wb2", 5'd9, 5'd4, 8'h99, 8'h44, 1'b0, 1'b0);

    // Set up r2 = 0x77 and three pending registers
    we0 = 1; wa0 = 5'd2; wd0 = 8'h77;
    issue = 1; issue_addr = 5'd12;
    step();
    issue = 1; issue_addr = 5'd13;
    step();
    issue = 1; issue_addr = 5'd14;
    step();
    check("pre_rst.count", 32'(busy_count), 32'd3);
    rd_check("pre_rst", 5'd2, 5'd12, 8'h77, 8'h00, 1'b0, 1'b1);

    // Reset mid-write for half a cycle
    step();
    we0 = 1; wa0 = 5'd20; wd0 = 8'hEE;
    issue = 1; issue_addr = 5'd15;
    #1 reset_n = 1'b0;
    #1;
    check("rst.count", 32'(busy_count), 32'd0);
    rd_check("rst.rd", 5'd2, 5'd13, 8'h00, 8'h00, 1'b0, 1'b0);
    we0 = 0; issue = 0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    step();
    check("post_rst.count", 32'(busy_count), 32'd0);
    rd_check("post_rst", 5'd20, 5'd15, 8'h00, 8'h00, 1'b0, 1'b0);
    rd_check("post_rst2", 5'd3, 5'd7, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Multi-port register file with a write-tracking scoreboard. It is the register storage for the pipelined core: `READ_PORTS` combinational read ports, two write ports (ALU writeback and load writeback), and one issue port that marks a destination register pending until its write lands. Register 0 is hardwired to zero. All registers and pending bits clear on reset.

## Interface
- `WIDTH`, 8: data width in bits.
- `ADDRESS_WIDTH`, 5: register address width; depth is `2**ADDRESS_WIDTH`.
- `READ_PORTS`, 2: number of read ports, 1..4.

- `clock`  in  1  the single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `we0`  in  1  write enable, port 0 (ALU writeback).
- `wa0`  in  ADDRESS_WIDTH  write address, port 0.
- `wd0`  in  WIDTH  write data, port 0.
- `we1`  in  1  write enable, port 1 (load writeback).
- `wa1`  in  ADDRESS_WIDTH  write address, port 1.
- `wd1`  in  WIDTH  write data, port 1.
- `issue`  in  1  marks `issue_addr` pending.
- `issue_addr`  in  ADDRESS_WIDTH  destination register of the issued instruction.
- `ra`  in  READ_PORTS*ADDRESS_WIDTH  packed read addresses; port k is at bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- `rd`  out  READ_PORTS*WIDTH  packed read data.
- `rbusy`  out  READ_PORTS  pending flag for each read address.
- `busy_count`  out  ADDRESS_WIDTH+1  number of registers currently pending.

## Operation
- Storage: `2**ADDRESS_WIDTH` × `WIDTH` array.
- Register 0:
  - reads return 0;
  - writes are ignored;
  - issue is ignored;
  - it is never busy.
- Writes commit at the rising edge when the enable is high and the address is nonzero.
- If `we0` and `we1` target the same address in one cycle, port 1 wins and port 0 is dropped.
- Each write clears that register's pending bit.
- `issue` with a nonzero `issue_addr` sets the pending bit at the rising edge.
- If issue and a write hit the same register in one cycle, the pending bit ends set: the new producer wins over the old writeback.
- Re-issuing a register that is already pending is legal; the bit stays set and `busy_count` does not change.
- `busy_count` is registered and equals the popcount of the pending bits.
  - It updates in the same edge as the bits.
  - Net change per cycle ranges from −2 to +1.
- Reads are combinational from the array and the pending bits. Read ports are independent, and several ports may read the same address.
- Reset (`reset_n` low, at any time, including mid-write): all registers read 0, all pending bits clear, `busy_count` is 0. State stays there until the first rising edge after `reset_n` is released.

## Timing
- Read latency: 0 cycles; `rd` and `rbusy` follow `ra` combinationally.
- Write-to-read latency: 1 edge without bypass, 0 with bypass (see Configuration).
- Issue-to-`rbusy`: visible after the next rising edge.
- Writeback-to-`rbusy` clear:
  - with bypass, 0 cycles;
  - without bypass, after the edge.
- Output values during reset: `rd` = 0, `rbusy` = 0, `busy_count` = 0.
- No handshake back-pressure: every enabled write and issue is accepted on every cycle.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - a read whose address matches an active write in the same cycle returns the write data (port 1 data if both ports match);
  - `rbusy` for that port reads 0 unless `issue` targets the same address in that cycle.
- Undefined:
  - reads return the stored value;
  - `rbusy` reflects the registered pending bit only;
  - the new value appears after the edge.

## Structure
- Package `regfile_pkg`:
  - `regfile_addr_t` and `regfile_data_t`, sized from package constants matching the defaults;
  - `REG_ZERO` = 0;
  - `MAX_READ_PORTS` = 4.
- Sub-module `regfile_scoreboard` owns the pending bit vector, the write/issue priority logic and `busy_count`. The top level holds the array, the write arbitration and the read muxes, and instantiates the scoreboard once.

## Test plan
1. Reset, then read all addresses on both ports → `rd` = 0 and `rbusy` = 0 everywhere; `busy_count` = 0.
2. Write 0xA5 to r3 via port 0, then read r3 the next cycle → 0xA5. Write 0xFF to r0, then read r0 → 0.
3. Same cycle: `we0` writes r7 = 0x11 and `we1` writes r7 = 0x22 → r7 = 0x22 afterwards. With `REGFILE_BYPASS_EN`, a same-cycle read of r7 returns 0x22.
4. Issue r5, then r9, then r5 again → `busy_count` steps 1, 2, 2. Write r5 → `busy_count` = 1 and `rbusy` for r5 = 0.
5. Same cycle: issue r4 while port 1 writes r4 = 0x3C → r4 = 0x3C, r4 remains busy, `busy_count` +1.
6. With 3 registers pending and r2 = 0x77, assert `reset_n` low for half a cycle mid-write → immediately `busy_count` = 0 and r2 reads 0; the interrupted write is lost.
